oai_resp_checker: RTL and testbench
===================================

Name: oai_resp_checker

Overview:
- Response-side monitor for the 3-input OAI gate test setup. It is the counterpart to the stimulus driver that applies (a,b,c) vectors to the three OAI implementations (switch-level, NOR-gate, Boolean).
- Watches the applied vector and the three DUT outputs. After a settle window it samples the outputs and compares each against the golden function y = ~((a|b)&c).
- Counts vectors checked and mismatches, and reports pass or fail at end of run.
- Synthesisable; usable inside a self-checking bench or an on-board BIST wrapper.

Parameters:
- SETTLE_CYC, 4, number of consecutive clk cycles abc must be stable before sampling (legal range 1..255).
- CNT_W, 8, width of the vector and error counters.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a checking run.
- stop  input  1  one-cycle pulse; ends the run.
- abc  input  3  applied vector {a,b,c}; a=bit2, c=bit0; synchronous to clk.
- dut_y  input  3  DUT outputs {switch, norGate, boolalg} = bits {0,1,2}.
- busy  output  1  high while a run is in progress.
- done  output  1  high in DONE until the next start.
- pass  output  1  valid when done=1.
- vec_cnt  output  CNT_W  vectors sampled.
- err_cnt  output  CNT_W  vectors with at least one mismatching DUT.
- mismatch  output  1  one-cycle pulse on a failing sample.
- mm_vec  output  3  abc of the most recent failing sample.
- mm_mask  output  3  per-DUT fail bits of the most recent failing sample.

Behaviour:
- Reset: all outputs 0; state IDLE; internal captured vector 0; settle counter 0.
- States: IDLE, SETTLE, SAMPLE, WAIT, DONE.
- IDLE / DONE, start=1:
  - clear vec_cnt, err_cnt, mm_vec, mm_mask and done;
  - capture abc into cap; clear the settle counter;
  - go to SETTLE. busy=1 in SETTLE, SAMPLE and WAIT.
- IDLE, stop=1: ignored.
- SETTLE:
  - if abc != cap: recapture abc and clear the counter (glitch restart).
  - else the counter increments; when it reaches SETTLE_CYC-1 with abc still equal to cap, go to SAMPLE.
  - With SETTLE_CYC=1 the block samples on the cycle after capture.
- SAMPLE (exactly 1 cycle):
  - g = ~((cap[2]|cap[1])&cap[0]); mask[i] = dut_y[i] ^ g.
  - vec_cnt increments.
  - if mask != 0: err_cnt increments; mismatch=1 in the following cycle; mm_vec <= cap; mm_mask <= mask.
  - go to WAIT.
- WAIT:
  - abc != cap: capture abc, clear the counter, go to SETTLE.
  - abc unchanged: remain in WAIT. A vector is sampled once, however long it is held.
- stop in SETTLE, SAMPLE or WAIT:
  - go to DONE next cycle; stop has priority over start and over abc changes.
  - in SETTLE, the unsampled vector is discarded.
  - in SAMPLE, that sample still updates the counters.
- start while busy: ignored.
- DONE: done=1, busy=0; pass = (err_cnt==0) && (vec_cnt!=0). Counters hold their values.
- Counters saturate at 2^CNT_W-1 and do not wrap; err_cnt <= vec_cnt always.
- rst_n low mid-run: immediate return to reset values; run lost.
- Golden table (abc -> y): y=0 only for 011, 101, 111; y=1 for the other five vectors.

Optional Feature:
- Macro: OAI_COV_EN.
- Defined:
  - adds output cov_map[7:0]; bit abc is set on every SAMPLE of that vector; cleared by start and by reset.
  - adds output cov_full = &cov_map.
  - pass additionally requires cov_full.
- Undefined: neither port exists; pass is as described above.
- Counters and FSM are identical in both builds.

Test Plan:
- Reset, start, then all 8 vectors held 10 cycles each, dut_y equal to golden on all bits, then stop -> vec_cnt=8, err_cnt=0, mismatch never high, done=1, pass=1 (cov_full=1 if OAI_COV_EN).
- abc=011 with dut_y=3'b010 (norGate outputs 1, golden 0) -> one mismatch pulse; mm_vec=011, mm_mask=010, err_cnt=1; pass=0 after stop.
- SETTLE_CYC=4; abc toggles 001->101->001 at 2-cycle intervals, then holds 001 for 6 cycles -> no sample during the toggling; exactly one sample (abc=001); vec_cnt=1.
- abc=100 held for 50 cycles with no change, then stop -> vec_cnt=1, not repeated.
- stop asserted 2 cycles after an abc change (still in SETTLE) -> DONE; that vector not counted; a start pulse in the same cycle is ignored.
- CNT_W=2; 5 distinct failing vectors -> vec_cnt=3, err_cnt=3 (saturated).
- rst_n pulsed low during WAIT -> all outputs 0, state IDLE; a subsequent start runs normally.

Source files
------------

// File: rtl/oai_resp_checker.sv
// oai_resp_checker
//   Response-side monitor for the 3-input OAI gate test setup. It watches the
//   applied vector abc and the three DUT outputs. Once abc has been stable for
//   SETTLE_CYC cycles, it samples each output and compares it against the
//   golden function y = ~((a|b)&c). It counts the vectors checked and the
//   mismatches, and reports pass or fail when the run ends.
//
// Ports
//   clk, rst_n     rising-edge clock; asynchronous active-low reset
//   start, stop    one-cycle pulses that begin and end a checking run
//   abc[2:0]       applied vector {a,b,c}
//   dut_y[2:0]     DUT outputs: bit0 switch-level, bit1 NOR-gate, bit2 Boolean
//   busy, done     run in progress / run finished (held until the next start)
//   pass           valid while done=1
//   vec_cnt        number of vectors sampled (saturating)
//   err_cnt        number of samples with at least one failing DUT (saturating)
//   mismatch       one-cycle pulse after each failing sample
//   mm_vec/mm_mask vector and per-DUT fail bits of the latest failing sample
//
// Optional build macro OAI_COV_EN adds the outputs cov_map[7:0] and cov_full.
// cov_map records which vectors have been sampled, and pass also requires
// full coverage.
module oai_resp_checker #(
  parameter int SETTLE_CYC = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [2:0]       abc,
  input  logic [2:0]       dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             mismatch,
  output logic [2:0]       mm_vec,
`ifdef OAI_COV_EN
  output logic [7:0]       cov_map,
  output logic             cov_full,
`endif
  output logic [2:0]       mm_mask
);

  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, WAIT, DONE} state_t;

  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state_q, state_d;
  logic [2:0]       cap_q, cap_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             mismatch_q, mismatch_d;
  logic [2:0]       mm_vec_q, mm_vec_d;
  logic [2:0]       mm_mask_q, mm_mask_d;
  logic [7:0]       cov_map_q, cov_map_d;

  logic             golden;
  logic [2:0]       mask;

  // The golden output for the captured vector, replicated across all three DUTs.
  assign golden = ~((cap_q[2] | cap_q[1]) & cap_q[0]);
  assign mask   = dut_y ^ {3{golden}};

  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    cnt_d      = cnt_q;
    vec_cnt_d  = vec_cnt_q;
    err_cnt_d  = err_cnt_q;
    mismatch_d = 1'b0;
    mm_vec_d   = mm_vec_q;
    mm_mask_d  = mm_mask_q;
    cov_map_d  = cov_map_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          vec_cnt_d = '0;
          err_cnt_d = '0;
          mm_vec_d  = '0;
          mm_mask_d = '0;
          cov_map_d = '0;
          cap_d     = abc;
          cnt_d     = '0;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        if (stop) begin
          state_d = DONE;
        end else if (abc != cap_q) begin
          // A glitch restarts the settle window on the new value.
          cap_d = abc;
          cnt_d = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SAMPLE: begin
        // This sample is still counted if stop arrives in the same cycle.
        if (vec_cnt_q != CNT_MAX) vec_cnt_d = vec_cnt_q + 1'b1;
        cov_map_d[cap_q] = 1'b1;
        if (mask != 3'b000) begin
          if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
          mismatch_d = 1'b1;
          mm_vec_d   = cap_q;
          mm_mask_d  = mask;
        end
        state_d = stop ? DONE : WAIT;
      end
      WAIT: begin
        if (stop) begin
          state_d = DONE;
        end else if (abc != cap_q) begin
          cap_d   = abc;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cap_q      <= '0;
      cnt_q      <= '0;
      vec_cnt_q  <= '0;
      err_cnt_q  <= '0;
      mismatch_q <= 1'b0;
      mm_vec_q   <= '0;
      mm_mask_q  <= '0;
      cov_map_q  <= '0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      cnt_q      <= cnt_d;
      vec_cnt_q  <= vec_cnt_d;
      err_cnt_q  <= err_cnt_d;
      mismatch_q <= mismatch_d;
      mm_vec_q   <= mm_vec_d;
      mm_mask_q  <= mm_mask_d;
      cov_map_q  <= cov_map_d;
    end
  end

  assign busy     = (state_q == SETTLE) || (state_q == SAMPLE) || (state_q == WAIT);
  assign done     = (state_q == DONE);
  assign vec_cnt  = vec_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign mismatch = mismatch_q;
  assign mm_vec   = mm_vec_q;
  assign mm_mask  = mm_mask_q;

`ifdef OAI_COV_EN
  assign cov_map  = cov_map_q;
  assign cov_full = &cov_map_q;
  assign pass     = done && (err_cnt_q == '0) && (vec_cnt_q != '0) && (&cov_map_q);
`else
  // Coverage tracking is not exported in this build, so the map is unused.
  logic cov_unused;
  assign cov_unused = ^cov_map_q;
  assign pass       = done && (err_cnt_q == '0) && (vec_cnt_q != '0);
`endif

endmodule

// File: tb/tb_oai_resp_checker.sv
module tb_oai_resp_checker;

  // Golden OAI table indexed by abc: y=0 only for 011, 101 and 111.
  localparam logic [7:0] GOLD = 8'b0101_0111;
`ifdef OAI_COV_EN
  localparam bit COV = 1'b1;
`else
  localparam bit COV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [2:0] abc = 3'd0;
  logic [2:0] dut_y = 3'd0;

  logic       busy, done, pass, mismatch;
  logic [7:0] vec_cnt, err_cnt;
  logic [2:0] mm_vec, mm_mask;
  logic       busy2, done2, pass2, mismatch2;
  logic [1:0] vec_cnt2, err_cnt2;
  logic [2:0] mm_vec2, mm_mask2;
`ifdef OAI_COV_EN
  logic [7:0] cov_map, cov_map2;
  logic       cov_full, cov_full2;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int mm_pulses = 0;
  int mm_base;

  always #5 clk = ~clk;

  oai_resp_checker #(.SETTLE_CYC(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .abc(abc), .dut_y(dut_y),
    .busy(busy), .done(done), .pass(pass), .vec_cnt(vec_cnt), .err_cnt(err_cnt),
    .mismatch(mismatch), .mm_vec(mm_vec),
`ifdef OAI_COV_EN
    .cov_map(cov_map), .cov_full(cov_full),
`endif
    .mm_mask(mm_mask)
  );

  // A narrow-counter instance that shares the same stimulus, used to check saturation.
  oai_resp_checker #(.SETTLE_CYC(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .abc(abc), .dut_y(dut_y),
    .busy(busy2), .done(done2), .pass(pass2), .vec_cnt(vec_cnt2), .err_cnt(err_cnt2),
    .mismatch(mismatch2), .mm_vec(mm_vec2),
`ifdef OAI_COV_EN
    .cov_map(cov_map2), .cov_full(cov_full2),
`endif
    .mm_mask(mm_mask2)
  );

  always @(posedge clk) if (mismatch) mm_pulses <= mm_pulses + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(1); stop = 1'b0;
  endtask

  // Apply a vector with correct (good=1) or fully inverted (good=0) DUT outputs.
  task automatic apply(input logic [2:0] v, input bit good);
    logic [7:0] t;
    t = GOLD;
    abc = v;
    dut_y = good ? {3{t[v]}} : {3{~t[v]}};
  endtask

  initial begin
    // Reset state.
    tick(2);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_vec", vec_cnt, 0);
    check("rst_err", err_cnt, 0);
    check("rst_mm", {mismatch, mm_vec, mm_mask}, 0);
    rst_n = 1'b1;
    tick(1);

    // All 8 vectors with correct outputs.
    mm_base = mm_pulses;
    apply(3'd0, 1'b1);
    pulse_start();
    check("t1_busy", busy, 1);
    for (int v = 0; v < 8; v++) begin
      apply(3'(v), 1'b1);
      tick(10);
    end
    pulse_stop();
    check("t1_vec", vec_cnt, 8);
    check("t1_err", err_cnt, 0);
    check("t1_mm_pulses", mm_pulses - mm_base, 0);
    check("t1_done", done, 1);
    check("t1_busy_off", busy, 0);
    check("t1_pass", pass, 1);
`ifdef OAI_COV_EN
    check("t1_cov_full", cov_full, 1);
`endif

    // NOR-gate DUT wrong on 011.
    mm_base = mm_pulses;
    abc = 3'b011; dut_y = 3'b010;
    pulse_start();
    check("t2_done_clr", done, 0);
    tick(10);
    check("t2_mm_pulses", mm_pulses - mm_base, 1);
    check("t2_mm_vec", mm_vec, 3'b011);
    check("t2_mm_mask", mm_mask, 3'b010);
    check("t2_err", err_cnt, 1);
    pulse_stop();
    check("t2_pass", pass, 0);

    // Glitching abc: a sample is taken only after a stable window.
    apply(3'b001, 1'b1);
    pulse_start();
    tick(2);
    apply(3'b101, 1'b1); tick(2);
    apply(3'b001, 1'b1); tick(2);
    apply(3'b101, 1'b1); tick(2);
    check("t3_vec_toggle", vec_cnt, 0);
    apply(3'b001, 1'b1); tick(6);
    check("t3_vec", vec_cnt, 1);
    pulse_stop();
    check("t3_vec_end", vec_cnt, 1);

    // A vector that is held for a long time is sampled only once.
    apply(3'b100, 1'b1);
    pulse_start();
    tick(50);
    check("t4_busy", busy, 1);
    pulse_stop();
    check("t4_vec", vec_cnt, 1);
    check("t4_pass", pass, COV ? 0 : 1);

    // Stop while in SETTLE, with a coincident start.
    apply(3'b010, 1'b1);
    pulse_start();
    tick(10);
    apply(3'b110, 1'b1);
    tick(2);
    stop = 1'b1; start = 1'b1;
    tick(1);
    stop = 1'b0; start = 1'b0;
    check("t5_done", done, 1);
    tick(5);
    check("t5_still_done", {done, busy}, 2'b10);
    check("t5_vec", vec_cnt, 1);

    // Five failing vectors: the 2-bit counters saturate at 3.
    apply(3'b011, 1'b0);
    pulse_start();
    tick(10);
    apply(3'b101, 1'b0); tick(10);
    apply(3'b111, 1'b0); tick(10);
    apply(3'b000, 1'b0); tick(10);
    apply(3'b001, 1'b0); tick(10);
    check("t6_vec8", vec_cnt, 5);
    check("t6_err8", err_cnt, 5);
    check("t6_vec2", vec_cnt2, 3);
    check("t6_err2", err_cnt2, 3);
    check("t6_mm_vec", mm_vec, 3'b001);
    check("t6_mm_mask", mm_mask, 3'b111);
    pulse_stop();
    check("t6_pass", pass, 0);

    // Asynchronous reset during WAIT, followed by a clean run.
    apply(3'b010, 1'b1);
    pulse_start();
    tick(10);
    check("t7_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t7_rst_busy", busy, 0);
    check("t7_rst_cnt", {vec_cnt, err_cnt}, 0);
    check("t7_rst_flags", {done, pass, mismatch}, 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    apply(3'b110, 1'b1);
    pulse_start();
    tick(10);
    pulse_stop();
    check("t7_vec", vec_cnt, 1);
    check("t7_done", done, 1);
    check("t7_pass", pass, COV ? 0 : 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
